// File: rtl/param_register_file.sv
// Two-read, one-write register file with byte enables,
// optional write-to-read forwarding and a hardwired zero entry.
module param_register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [WIDTH-1:0]  Data,
  input  logic [WIDTH/8-1:0] BE,
  input  logic [ADDR_W-1:0] Raddr1,
  input  logic [ADDR_W-1:0] Raddr2,
  output logic [WIDTH-1:0]  Dout1,
  output logic [WIDTH-1:0]  Dout2
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] bmask;
  logic [WIDTH-1:0] wold;
  logic [WIDTH-1:0] merged;
  logic             wlegal;
  logic             wvalid;

  logic [ADDR_W-1:0] ra [2];
  logic [WIDTH-1:0]  rd [2];

  always_comb begin
    bmask = '0;
    for (int i = 0; i < NB; i++) begin
      bmask[8*i +: 8] = {8{BE[i]}};
    end
  end

  always_comb begin
    wlegal = ({1'b0, Waddr} < DEPTH_L) && !(ZR && (Waddr == '0));
    wold   = wlegal ? mem[Waddr] : '0;
    merged = (Data & bmask) | (wold & ~bmask);
    wvalid = WE && wlegal && !reset;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (wvalid) begin
      mem[Waddr] <= merged;
    end
  end

  assign ra[0] = Raddr1;
  assign ra[1] = Raddr2;

  // forwarding overrides the array only for a write that will land
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      if (({1'b0, ra[p]} < DEPTH_L) && !(ZR && (ra[p] == '0))) begin
        rd[p] = mem[ra[p]];
      end
      if (BP && wvalid && (ra[p] == Waddr)) begin
        rd[p] = merged;
      end
    end
  end

  assign Dout1 = rd[0];
  assign Dout2 = rd[1];

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: one forwarding and
// one non-forwarding instance driven from shared stimulus.
module tb_param_register_file;

  localparam logic [31:0] RV = 32'h0000_0A5A;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        WE = 1'b0;
  logic [4:0]  Waddr = '0;
  logic [31:0] Data = '0;
  logic [3:0]  BE = '0;
  logic [4:0]  Raddr1 = '0;
  logic [4:0]  Raddr2 = '0;
  logic [31:0] a1, a2, b1, b2;

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] exp_mem [24];

  always #5 CLK = ~CLK;

  param_register_file #(
    .WIDTH(32), .DEPTH(24), .BYPASS(1),
    .ZERO_REG(1), .RESET_VAL(RV)
  ) dut_a (
    .CLK(CLK), .reset(reset), .WE(WE), .Waddr(Waddr),
    .Data(Data), .BE(BE), .Raddr1(Raddr1), .Raddr2(Raddr2),
    .Dout1(a1), .Dout2(a2)
  );

  param_register_file #(
    .WIDTH(32), .DEPTH(24), .BYPASS(0),
    .ZERO_REG(1), .RESET_VAL(RV)
  ) dut_b (
    .CLK(CLK), .reset(reset), .WE(WE), .Waddr(Waddr),
    .Data(Data), .BE(BE), .Raddr1(Raddr1), .Raddr2(Raddr2),
    .Dout1(b1), .Dout2(b2)
  );

  task automatic do_write(input logic [4:0] ad,
                          input logic [31:0] d,
                          input logic [3:0] be);
    logic [31:0] m;
    @(negedge CLK);
    WE = 1'b1; Waddr = ad; Data = d; BE = be;
    @(posedge CLK);
    #1;
    WE = 1'b0;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (ad < 5'd24 && ad != 5'd0)
      exp_mem[ad] = (d & m) | (exp_mem[ad] & ~m);
  endtask

  task automatic test_reset;
    @(negedge CLK);
    #2;
    Raddr1 = 5'd5; Raddr2 = 5'd0;
    reset = 1'b1;
    #1;
    ncmp++;
    if (a1 !== RV) begin
      $display("FAIL reset_async_a5: got %h want %h", a1, RV);
      nerr++;
    end
    ncmp++;
    if (a2 !== 32'h0) begin
      $display("FAIL reset_zero_a: got %h want %h", a2, 32'h0);
      nerr++;
    end
    ncmp++;
    if (b1 !== RV) begin
      $display("FAIL reset_async_b5: got %h want %h", b1, RV);
      nerr++;
    end
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) exp_mem[i] = RV;
  endtask

  task automatic test_full_write;
    do_write(5'd3, 32'h0000_07FF, 4'hF);
    Raddr1 = 5'd3; Raddr2 = 5'd4;
    #1;
    ncmp++;
    if (a1 !== 32'h0000_07FF) begin
      $display("FAIL full_wr_a3: got %h want %h", a1, 32'h0000_07FF);
      nerr++;
    end
    ncmp++;
    if (a2 !== RV) begin
      $display("FAIL full_wr_a4: got %h want %h", a2, RV);
      nerr++;
    end
    ncmp++;
    if (b1 !== 32'h0000_07FF) begin
      $display("FAIL full_wr_b3: got %h want %h", b1, 32'h0000_07FF);
      nerr++;
    end
  endtask

  task automatic test_byte_enable;
    do_write(5'd3, 32'h1122_3344, 4'hF);
    do_write(5'd3, 32'hAABB_CCDD, 4'b0101);
    Raddr1 = 5'd3; Raddr2 = 5'd3;
    #1;
    ncmp++;
    if (a1 !== 32'h11BB_33DD) begin
      $display("FAIL be_merge_a: got %h want %h", a1, 32'h11BB_33DD);
      nerr++;
    end
    ncmp++;
    if (b2 !== 32'h11BB_33DD) begin
      $display("FAIL be_merge_b: got %h want %h", b2, 32'h11BB_33DD);
      nerr++;
    end
    do_write(5'd3, 32'hFFFF_FFFF, 4'b0000);
    #1;
    ncmp++;
    if (a1 !== 32'h11BB_33DD) begin
      $display("FAIL be_zero: got %h want %h", a1, 32'h11BB_33DD);
      nerr++;
    end
    do_write(5'd3, 32'h5566_7788, 4'b1000);
    #1;
    ncmp++;
    if (a2 !== 32'h55BB_33DD) begin
      $display("FAIL be_top: got %h want %h", a2, 32'h55BB_33DD);
      nerr++;
    end
  endtask

  task automatic test_bypass;
    do_write(5'd7, 32'h0, 4'hF);
    @(negedge CLK);
    WE = 1'b1; Waddr = 5'd7; Data = 32'h0000_02FF; BE = 4'hF;
    Raddr1 = 5'd7; Raddr2 = 5'd7;
    #1;
    ncmp++;
    if (a1 !== 32'h0000_02FF) begin
      $display("FAIL byp_a1: got %h want %h", a1, 32'h0000_02FF);
      nerr++;
    end
    ncmp++;
    if (a2 !== 32'h0000_02FF) begin
      $display("FAIL byp_a2: got %h want %h", a2, 32'h0000_02FF);
      nerr++;
    end
    ncmp++;
    if (b1 !== 32'h0) begin
      $display("FAIL nobyp_b1: got %h want %h", b1, 32'h0);
      nerr++;
    end
    @(posedge CLK);
    #1;
    WE = 1'b0;
    exp_mem[7] = 32'h0000_02FF;
    ncmp++;
    if (b1 !== 32'h0000_02FF) begin
      $display("FAIL nobyp_after: got %h want %h", b1, 32'h0000_02FF);
      nerr++;
    end
    // partial-byte forwarding merges with the stored entry
    @(negedge CLK);
    WE = 1'b1; Waddr = 5'd7; Data = 32'h1234_5678; BE = 4'b0001;
    #1;
    ncmp++;
    if (a1 !== 32'h0000_0278) begin
      $display("FAIL byp_merge: got %h want %h", a1, 32'h0000_0278);
      nerr++;
    end
    ncmp++;
    if (b2 !== 32'h0000_02FF) begin
      $display("FAIL nobyp_merge: got %h want %h", b2, 32'h0000_02FF);
      nerr++;
    end
    @(posedge CLK);
    #1;
    WE = 1'b0;
    exp_mem[7] = 32'h0000_0278;
  endtask

  task automatic test_zero_range;
    @(negedge CLK);
    WE = 1'b1; Waddr = 5'd0; Data = 32'hFFFF_FFFF; BE = 4'hF;
    Raddr1 = 5'd0; Raddr2 = 5'd30;
    #1;
    ncmp++;
    if (a1 !== 32'h0) begin
      $display("FAIL zero_byp: got %h want %h", a1, 32'h0);
      nerr++;
    end
    @(posedge CLK);
    #1;
    WE = 1'b0;
    do_write(5'd30, 32'hFFFF_FFFF, 4'hF);
    Raddr1 = 5'd0; Raddr2 = 5'd30;
    #1;
    ncmp++;
    if (a1 !== 32'h0) begin
      $display("FAIL zero_rd: got %h want %h", a1, 32'h0);
      nerr++;
    end
    ncmp++;
    if (a2 !== 32'h0) begin
      $display("FAIL range_rd: got %h want %h", a2, 32'h0);
      nerr++;
    end
    for (int i = 1; i < 24; i++) begin
      Raddr1 = 5'(i); Raddr2 = 5'(i);
      #1;
      ncmp++;
      if (a1 !== exp_mem[i] || b2 !== exp_mem[i]) begin
        $display("FAIL keep_%0d: got %h/%h want %h",
                 i, a1, b2, exp_mem[i]);
        nerr++;
      end
    end
  endtask

  task automatic test_reset_vs_write;
    @(negedge CLK);
    reset = 1'b1;
    WE = 1'b1; Waddr = 5'd2; Data = 32'h0000_1FFF; BE = 4'hF;
    Raddr1 = 5'd2; Raddr2 = 5'd3;
    #1;
    ncmp++;
    if (a1 !== RV) begin
      $display("FAIL rst_nobyp: got %h want %h", a1, RV);
      nerr++;
    end
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0; WE = 1'b0;
    #1;
    for (int i = 0; i < 24; i++) exp_mem[i] = RV;
    ncmp++;
    if (a1 !== RV || b1 !== RV) begin
      $display("FAIL rst_win: got %h/%h want %h", a1, b1, RV);
      nerr++;
    end
    ncmp++;
    if (a2 !== RV) begin
      $display("FAIL rst_clear3: got %h want %h", a2, RV);
      nerr++;
    end
    do_write(5'd2, 32'h0000_1234, 4'hF);
    #1;
    ncmp++;
    if (a1 !== 32'h0000_1234 || b1 !== 32'h0000_1234) begin
      $display("FAIL post_rst_wr: got %h/%h want %h",
               a1, b1, 32'h0000_1234);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_enable();
    test_bypass();
    test_zero_range();
    test_reset_vs_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of entries (2..256).
REQ-003 The block SHALL have parameter BYPASS, default 1; 1 forwards same-cycle write data to the read ports, 0 gives no forwarding.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; 1 hardwires entry 0 to zero.
REQ-005 The block SHALL have parameter RESET_VAL, default 0, a WIDTH-bit value loaded into every entry on reset.
REQ-006 The block SHALL derive local ADDR_W = clog2(DEPTH), with a minimum of 1.

Ports (name  direction  width  meaning):
REQ-007 CLK  input  1  the single clock; all state updates occur on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 WE  input  1  write enable.
REQ-010 Waddr  input  ADDR_W  write address.
REQ-011 Data  input  WIDTH  write data.
REQ-012 BE  input  WIDTH/8  byte enables; bit i covers Data[8i+7:8i].
REQ-013 Raddr1, Raddr2  input  ADDR_W  read addresses for ports 1 and 2.
REQ-014 Dout1, Dout2  output  WIDTH  read data for ports 1 and 2.

Function
REQ-015 On a rising CLK edge with reset=0, WE=1 and Waddr<DEPTH, the block SHALL update each byte of entry Waddr whose BE bit is 1 and SHALL keep every other byte unchanged.
REQ-016 A write with BE all-zero SHALL leave the entry unchanged.
REQ-017 A write with Waddr>=DEPTH SHALL be ignored, and no entry SHALL change.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be ignored, and reads of address 0 SHALL return 0 on both ports.
REQ-019 Reads SHALL be combinational with zero cycle latency: Doutn = entry[Raddrn], or 0 when Raddrn>=DEPTH.
REQ-020 With BYPASS=1, when WE=1 and Raddrn==Waddr for a valid, writable address with reset=0, Doutn SHALL show, in the same cycle, the merged value (BE-selected bytes from Data, remaining bytes from the stored entry).
REQ-021 With BYPASS=0, under the same condition Doutn SHALL show the old stored value until after the edge.
REQ-022 Both ports SHALL be independent; equal Raddr1 and Raddr2 SHALL give identical outputs, including under bypass.
REQ-023 The block SHALL contain no internal state other than the DEPTH x WIDTH storage array.

Reset
REQ-024 While reset=1, every entry SHALL be set to RESET_VAL asynchronously, without waiting for CLK; entry 0 SHALL read 0 when ZERO_REG=1.
REQ-025 While reset=1, writes and bypass SHALL be suppressed, and Dout1/Dout2 SHALL reflect the reset contents.
REQ-026 Reset asserted in the same cycle as a write SHALL win, and the entry SHALL hold RESET_VAL.
REQ-027 After reset deasserts, the first rising CLK edge with WE=1 SHALL perform a normal write.

Verification
REQ-028 Reset: RESET_VAL=32'h0000_0A5A; assert reset mid-cycle with no CLK edge -> Dout1 at Raddr1=5 reads 32'h0000_0A5A immediately, and Raddr1=0 reads 0.
REQ-029 Full write/read: WE=1, Waddr=3, Data=32'h0000_07FF, BE=4'hF, one edge -> Raddr1=3 reads 32'h0000_07FF, and Raddr2=4 reads RESET_VAL.
REQ-030 Byte enables: entry 3=32'h1122_3344, then write Data=32'hAABB_CCDD with BE=4'b0101 -> entry 3 reads 32'h11BB_33DD.
REQ-031 Bypass: BYPASS=1, entry 7=0, WE=1, Waddr=Raddr1=7, Data=32'h0000_02FF before the edge -> Dout1=32'h0000_02FF in the same cycle; with BYPASS=0 -> Dout1=0 until the edge.
REQ-032 Zero and range: write 32'hFFFF_FFFF to address 0, and (with DEPTH=24) to address 30 -> Dout at address 0 reads 0, address 30 reads 0, and all other entries are unchanged.
REQ-033 Reset versus write: reset=1 together with WE=1, Waddr=2, Data=32'h0000_1FFF across an edge -> entry 2 equals RESET_VAL after reset deasserts.
